// File: rtl/axi4_mult_pkg.sv
// Shared types and constants for the AXI4 multiplier master.
package axi4_mult_pkg;

   // Sequencer states: write A, write B, read product, present result.
   typedef enum logic [3:0] {
      StIdle,
      StAwA,
      StWA,
      StBA,
      StAwB,
      StWB,
      StBB,
      StAr,
      StR,
      StDone
   } state_e;

   // Slave register map: operands at 0 and 1, product read back from 0.
   localparam int unsigned ADDR_A   = 0;
   localparam int unsigned ADDR_B   = 1;
   localparam int unsigned ADDR_RES = 0;

   // This slave encodes a good response as 1.
   localparam logic OK_RESP = 1'b1;

endpackage

// File: rtl/axi4_burst_ser.sv
// Serialises one SZ-bit word into SZ/DSZ write beats, LSB first, with wlast.
module axi4_burst_ser
   import axi4_mult_pkg::*;
#(
   parameter int unsigned SZ  = 32,
   parameter int unsigned DSZ = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           load,
   input  logic [SZ-1:0]  word,
   output logic [DSZ-1:0] wdata,
   output logic           wvalid,
   output logic           wlast,
   input  logic           wready
);

   localparam int unsigned NB = SZ / DSZ;
   localparam int unsigned CW = (NB > 1) ? $clog2(NB) : 1;

   logic [SZ-1:0] shift;
   logic [CW-1:0] beat;

   // Load presents beat 0 at once; each accepted beat exposes the next until wlast is taken.
   always_ff @(posedge clk) begin
      if (rst) begin
         shift  <= '0;
         beat   <= '0;
         wdata  <= '0;
         wvalid <= 1'b0;
         wlast  <= 1'b0;
      end else if (load) begin
         shift  <= word >> DSZ;
         beat   <= '0;
         wdata  <= word[DSZ-1:0];
         wvalid <= 1'b1;
         wlast  <= (NB == 1);
      end else if (wvalid && wready) begin
         if (wlast) begin
            wvalid <= 1'b0;
            wlast  <= 1'b0;
            wdata  <= '0;
         end else begin
            shift <= shift >> DSZ;
            beat  <= beat + 1'b1;
            wdata <= shift[DSZ-1:0];
            wlast <= (beat == CW'(NB - 2));
         end
      end
   end

endmodule

// File: rtl/axi4_mult_master.sv
// AXI4 master that writes two operands to a multiplier slave and reads back the product.
module axi4_mult_master
   import axi4_mult_pkg::*;
#(
   parameter int unsigned SZ  = 32,
   parameter int unsigned ASZ = 2,
   parameter int unsigned DSZ = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic [SZ-1:0]   cmd_a,
   input  logic [SZ-1:0]   cmd_b,
   output logic            res_valid,
   input  logic            res_ready,
   output logic [2*SZ-1:0] res,
   output logic            res_err,
   output logic [ASZ-1:0]  awaddr,
   output logic            awvalid,
   input  logic            awready,
   output logic [DSZ-1:0]  wdata,
   output logic            wvalid,
   output logic            wlast,
   input  logic            wready,
   input  logic            bresp,
   input  logic            bvalid,
   output logic            bready,
   output logic [ASZ-1:0]  araddr,
   output logic            arvalid,
   input  logic            arready,
   input  logic [DSZ-1:0]  rdata,
   input  logic            rvalid,
   input  logic            rlast,
   input  logic            rresp,
   output logic            rready
);

   localparam int unsigned NB  = SZ / DSZ;
   localparam int unsigned RB  = 2 * NB;
   localparam int unsigned RCW = $clog2(RB + 1);

   state_e         state;
   logic [SZ-1:0]  op_a;
   logic [SZ-1:0]  op_b;
   logic [RCW-1:0] rcnt;
   logic           ser_load;
   logic [SZ-1:0]  ser_word;
   logic           w_done;

   // Hand the operand over on the AW handshake so beat 0 is on the bus the next cycle.
   assign ser_load = awvalid && awready;
   assign ser_word = (state == StAwB) ? op_b : op_a;
   assign w_done   = wvalid && wready && wlast;

   axi4_burst_ser #(
      .SZ  (SZ),
      .DSZ (DSZ)
   ) u_ser (
      .clk    (clk),
      .rst    (rst),
      .load   (ser_load),
      .word   (ser_word),
      .wdata  (wdata),
      .wvalid (wvalid),
      .wlast  (wlast),
      .wready (wready)
   );

   // Transaction sequencer; every interface output is a flop set on the edge entering its state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= StIdle;
         cmd_ready <= 1'b1;
         res_valid <= 1'b0;
         res       <= '0;
         res_err   <= 1'b0;
         awvalid   <= 1'b0;
         awaddr    <= '0;
         bready    <= 1'b0;
         arvalid   <= 1'b0;
         araddr    <= '0;
         rready    <= 1'b0;
         op_a      <= '0;
         op_b      <= '0;
         rcnt      <= '0;
      end else begin
         unique case (state)
            StIdle: begin
               if (cmd_valid && cmd_ready) begin
                  op_a      <= cmd_a;
                  op_b      <= cmd_b;
                  res_err   <= 1'b0;
                  res       <= '0;
                  cmd_ready <= 1'b0;
                  awvalid   <= 1'b1;
                  awaddr    <= ASZ'(ADDR_A);
                  state     <= StAwA;
               end
            end
            StAwA: begin
               if (awready) begin
                  awvalid <= 1'b0;
                  awaddr  <= '0;
                  state   <= StWA;
               end
            end
            StWA: begin
               if (w_done) begin
                  bready <= 1'b1;
                  state  <= StBA;
               end
            end
            StBA: begin
               if (bvalid) begin
                  bready <= 1'b0;
                  if (bresp != OK_RESP) res_err <= 1'b1;
                  awvalid <= 1'b1;
                  awaddr  <= ASZ'(ADDR_B);
                  state   <= StAwB;
               end
            end
            StAwB: begin
               if (awready) begin
                  awvalid <= 1'b0;
                  awaddr  <= '0;
                  state   <= StWB;
               end
            end
            StWB: begin
               if (w_done) begin
                  bready <= 1'b1;
                  state  <= StBB;
               end
            end
            StBB: begin
               if (bvalid) begin
                  bready <= 1'b0;
                  if (bresp != OK_RESP) res_err <= 1'b1;
                  arvalid <= 1'b1;
                  araddr  <= ASZ'(ADDR_RES);
                  state   <= StAr;
               end
            end
            StAr: begin
               if (arready) begin
                  arvalid <= 1'b0;
                  araddr  <= '0;
                  rready  <= 1'b1;
                  rcnt    <= '0;
                  state   <= StR;
               end
            end
            StR: begin
               if (rvalid) begin
                  // Beats past the product width are dropped; the count sticks at RB.
                  if (rcnt < RCW'(RB)) res[int'(rcnt)*DSZ +: DSZ] <= rdata;
                  if (rcnt != RCW'(RB)) rcnt <= rcnt + 1'b1;
                  if (rresp != OK_RESP) res_err <= 1'b1;
                  if (rlast) begin
                     if (rcnt != RCW'(RB - 1)) res_err <= 1'b1;
                     rready    <= 1'b0;
                     res_valid <= 1'b1;
                     state     <= StDone;
                  end
               end
            end
            StDone: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  cmd_ready <= 1'b1;
                  state     <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_axi4_mult_master.sv
// Bench for axi4_mult_master: behavioural AXI multiplier slave plus a per-cycle checker.
module tb_axi4_mult_master;

   localparam int unsigned SZ  = 32;
   localparam int unsigned ASZ = 2;
   localparam int unsigned DSZ = 8;
   localparam int unsigned NB  = SZ / DSZ;
   localparam int unsigned LAT = 2 * (NB + 2) + 1 + 2 * NB;

   logic            clk = 1'b0;
   logic            rst;
   logic            cmd_valid, cmd_ready;
   logic [SZ-1:0]   cmd_a, cmd_b;
   logic            res_valid, res_ready;
   logic [2*SZ-1:0] res;
   logic            res_err;
   logic [ASZ-1:0]  awaddr, araddr;
   logic            awvalid, awready, wvalid, wlast, wready;
   logic [DSZ-1:0]  wdata, rdata;
   logic            bresp, bvalid, bready, arvalid, arready;
   logic            rvalid, rlast, rresp, rready;

   int errors = 0;
   int checks = 0;

   axi4_mult_master #(
      .SZ  (SZ),
      .ASZ (ASZ),
      .DSZ (DSZ)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_a     (cmd_a),
      .cmd_b     (cmd_b),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res       (res),
      .res_err   (res_err),
      .awaddr    (awaddr),
      .awvalid   (awvalid),
      .awready   (awready),
      .wdata     (wdata),
      .wvalid    (wvalid),
      .wlast     (wlast),
      .wready    (wready),
      .bresp     (bresp),
      .bvalid    (bvalid),
      .bready    (bready),
      .araddr    (araddr),
      .arvalid   (arvalid),
      .arready   (arready),
      .rdata     (rdata),
      .rvalid    (rvalid),
      .rlast     (rlast),
      .rresp     (rresp),
      .rready    (rready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- slave ----------------
   logic           rand_ready = 1'b0;
   logic           bad_bresp  = 1'b0;
   int             rlast_at   = 2 * NB - 1;
   logic [ASZ-1:0] wr_addr;
   logic [SZ-1:0]  wbuf, mem_a, mem_b;
   logic [63:0]    prod;
   int             rbeat;

   assign prod = {32'b0, mem_a} * {32'b0, mem_b};

   function automatic logic [DSZ-1:0] byte_of(input logic [63:0] v, input int k);
      if (k < 2 * NB) return v[k*DSZ +: DSZ];
      return 8'hA5;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         awready <= 1'b0;
         wready  <= 1'b0;
         arready <= 1'b0;
         bvalid  <= 1'b0;
         bresp   <= 1'b1;
         rvalid  <= 1'b0;
         rlast   <= 1'b0;
         rdata   <= '0;
         rresp   <= 1'b1;
         rbeat   <= 0;
         wbuf    <= '0;
         wr_addr <= '0;
      end else begin
         awready <= rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         wready  <= rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         arready <= 1'b1;
         if (awvalid && awready) wr_addr <= awaddr;
         if (wvalid && wready) begin
            wbuf <= {wdata, wbuf[SZ-1:DSZ]};
            if (wlast) begin
               if (wr_addr == ASZ'(1)) mem_b <= {wdata, wbuf[SZ-1:DSZ]};
               else                    mem_a <= {wdata, wbuf[SZ-1:DSZ]};
               bvalid <= 1'b1;
               bresp  <= ~bad_bresp;
            end
         end else if (bvalid && bready) begin
            bvalid <= 1'b0;
         end
         if (arvalid && arready) begin
            rbeat  <= 0;
            rvalid <= 1'b1;
            rdata  <= byte_of(prod, 0);
            rlast  <= (rlast_at == 0);
         end else if (rvalid && rready) begin
            if (rlast) begin
               rvalid <= 1'b0;
               rlast  <= 1'b0;
            end else begin
               rbeat <= rbeat + 1;
               rdata <= byte_of(prod, rbeat + 1);
               rlast <= (rbeat + 1 == rlast_at);
            end
         end
      end
   end

   // ---------------- reference model and checker ----------------
   bit             busy, got_res, timed, chk_res, exp_err, rst_seen;
   logic [63:0]    exp_res, last_res, res_h;
   logic           last_err, err_h;
   int             lat, w_hs;
   logic [DSZ-1:0] exp_beat_q[$];
   logic           exp_last_q[$];
   logic [ASZ-1:0] exp_aw_q[$];
   logic [DSZ-1:0] seen_beats[$];
   bit             aw_hold, w_hold, r_hold;
   logic [ASZ-1:0] aw_addr_h;
   logic [DSZ-1:0] w_data_h;
   logic           w_last_h;

   initial begin
      logic [SZ-1:0] tmp;
      forever begin
         @(negedge clk);
         if (rst) begin
            busy = 0; got_res = 0; rst_seen = 1;
            aw_hold = 0; w_hold = 0; r_hold = 0;
            exp_beat_q.delete(); exp_last_q.delete(); exp_aw_q.delete();
         end else begin
            if (rst_seen) begin
               chk("rst_cmd_ready", cmd_ready, 1);
               chk("rst_res_valid", res_valid, 0);
               chk("rst_res", res, 0);
               chk("rst_res_err", res_err, 0);
               chk("rst_valids", {awvalid, wvalid, wlast, bready, arvalid, rready}, 0);
               chk("rst_addr_data", {awaddr, araddr, wdata}, 0);
               rst_seen = 0;
            end
            lat++;
            if (aw_hold) chk("aw_stable", {awvalid, awaddr}, {1'b1, aw_addr_h});
            if (w_hold) chk("w_stable", {wvalid, wlast, wdata}, {1'b1, w_last_h, w_data_h});
            if (r_hold) chk("res_stable", {res_valid, res_err, res}, {1'b1, err_h, res_h});
            chk("cmd_ready", cmd_ready, !busy);
            if (!busy) chk("res_valid_idle", res_valid, 0);

            if (awvalid && awready) begin
               if (exp_aw_q.size() == 0) chk("aw_unexpected", awvalid, 0);
               else chk("awaddr", awaddr, exp_aw_q.pop_front());
            end
            if (wvalid && wready) begin
               seen_beats.push_back(wdata);
               w_hs++;
               if (exp_beat_q.size() == 0) chk("w_unexpected", wvalid, 0);
               else begin
                  chk("wdata", wdata, exp_beat_q.pop_front());
                  chk("wlast", wlast, exp_last_q.pop_front());
               end
            end
            if (arvalid && arready) chk("araddr", araddr, 0);

            if (res_valid && !got_res) begin
               got_res  = 1;
               last_res = res;
               last_err = res_err;
               if (timed) chk("latency", lat, LAT);
               if (chk_res) chk("res", res, exp_res);
               chk("res_err", res_err, exp_err);
            end

            aw_hold = awvalid && !awready;  aw_addr_h = awaddr;
            w_hold  = wvalid && !wready;    w_data_h = wdata;  w_last_h = wlast;
            r_hold  = res_valid && !res_ready;  res_h = res;  err_h = res_err;

            if (res_valid && res_ready) begin
               busy = 0;
               got_res = 0;
            end
            if (cmd_valid && cmd_ready) begin
               busy = 1;
               lat  = -1;
               w_hs = 0;
               for (int k = 0; k < NB; k++) begin
                  tmp = cmd_a >> (DSZ * k);
                  exp_beat_q.push_back(tmp[DSZ-1:0]);
                  exp_last_q.push_back(k == NB - 1);
               end
               for (int k = 0; k < NB; k++) begin
                  tmp = cmd_b >> (DSZ * k);
                  exp_beat_q.push_back(tmp[DSZ-1:0]);
                  exp_last_q.push_back(k == NB - 1);
               end
               exp_aw_q.push_back(ASZ'(0));
               exp_aw_q.push_back(ASZ'(1));
               exp_res = {32'b0, cmd_a} * {32'b0, cmd_b};
               chk_res = (rlast_at == 2 * NB - 1);
               exp_err = bad_bresp || !chk_res;
               timed   = !rand_ready && chk_res;
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic do_cmd(input logic [SZ-1:0] a, input logic [SZ-1:0] b, input int hold);
      int n;
      n = 0;
      while (!cmd_ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (!cmd_ready) begin
         chk("cmd_ready_timeout", cmd_ready, 1);
         return;
      end
      cmd_a = a;
      cmd_b = b;
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      n = 0;
      while (!res_valid && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      if (!res_valid) begin
         chk("res_timeout", res_valid, 1);
         return;
      end
      repeat (hold) begin
         @(posedge clk); #1;
      end
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
   endtask

   logic [DSZ-1:0] lit_beats[8] = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};

   initial begin
      int n;
      cmd_valid = 1'b0;
      cmd_a     = '0;
      cmd_b     = '0;
      res_ready = 1'b0;
      rst       = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // 3 x 5 with an always-ready slave
      seen_beats.delete();
      do_cmd(32'd3, 32'd5, 0);
      chk("lit_res_3x5", last_res, 64'h0F);
      chk("lit_err_3x5", last_err, 0);
      chk("lit_beat_count", seen_beats.size(), 8);
      for (int k = 0; k < 8 && k < seen_beats.size(); k++) chk("lit_beat", seen_beats[k], lit_beats[k]);

      // all ones
      do_cmd(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      chk("lit_res_ones", last_res, 64'hFFFF_FFFE_0000_0001);
      chk("lit_err_ones", last_err, 0);

      // random awready/wready back-pressure
      rand_ready = 1'b1;
      seen_beats.delete();
      do_cmd(32'd3, 32'd5, 0);
      chk("lit_res_rand", last_res, 64'h0F);
      chk("lit_beat_count_rand", seen_beats.size(), 8);
      for (int k = 0; k < 8 && k < seen_beats.size(); k++) chk("lit_beat_rand", seen_beats[k], lit_beats[k]);
      rand_ready = 1'b0;

      // bad write response
      bad_bresp = 1'b1;
      do_cmd(32'd7, 32'd9, 0);
      chk("lit_err_bresp", last_err, 1);
      bad_bresp = 1'b0;

      // early rlast on read beat 5
      rlast_at = 5;
      do_cmd(32'd7, 32'd9, 0);
      chk("lit_err_rlast", last_err, 1);
      rlast_at = 2 * NB - 1;

      // reset in the middle of the operand A burst, on beat 2
      cmd_a = 32'hDEAD_BEEF;
      cmd_b = 32'h1234_5678;
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      n = 0;
      while (w_hs != 2 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("w_beat2_reached", w_hs, 2);
      chk("mid_burst_wvalid", wvalid, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;

      // new command after the abort, result held off for 10 cycles
      do_cmd(32'h1234_5678, 32'h10, 10);
      chk("lit_res_hold", last_res, 64'h0000_0001_2345_6780);
      chk("idle_after_hold", cmd_ready, 1);
      chk("res_valid_after_hold", res_valid, 0);

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

endmodule
